piso_serializer: RTL and testbench

- Parallel-in/serial-out transmitter. It is the sending end paired with the team's 4-bit SIPO receiver.
- Accepts a WIDTH-bit word through a ready/load handshake and shifts it out one bit per clock on sout.
- sout_valid frames the shifted bits and done marks the last bit.
- Sits between a word-producing datapath and a serial link feeding a SIPO.

---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_serializer_if.sv | 30 +++
 rtl/piso_serializer.sv | 112 +++++++++++
 tb/tb_piso_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and helpers for the PISO serializer
package piso_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A 2-bit word still needs a 1-bit counter, where $clog2(2) alone would give 1 anyway
    // but $clog2 of smaller values would collapse to zero width.
    function automatic int cnt_width(input int width);
        return (width <= WIDTH_MIN) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word-load handshake and serial output bundle
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] pin;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output load,
        output pin,
        input  ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  load,
        input  pin,
        output ready,
        output sout,
        output sout_valid,
        output done
    );

endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with ready/load handshake
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             last_bit;
    logic             ready;
    logic             accept;

    logic             sout_q;
    logic             sout_valid_q;
    logic             done_q;
    logic             sout_d;
    logic             sout_valid_d;
    logic             done_d;

    // The last-bit cycle is also a load window, which is what makes back-to-back words gapless.
    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign ready    = rst && ((state == IDLE) || last_bit);
    assign accept   = bus.load && ready;

    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            cnt          <= cnt_nxt;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = bus.pin;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        shreg_nxt = bus.pin;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
                    end
                end else begin
                    shreg_nxt = shreg_shifted;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state and registered, so they line up with shreg/cnt.
    always_comb begin
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;
        if (state_nxt == SHIFT) begin
            sout_d       = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
            sout_valid_d = 1'b1;
            done_d       = (cnt_nxt == LAST);
        end
    end

    assign bus.ready      = ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB- and LSB-first instances)
module tb_piso_serializer;

    localparam int W     = 4;
    localparam int DEPTH = 16384;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] pin;
    logic         end_req;

    piso_serializer_if #(.WIDTH(W)) bus_m ();
    piso_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.load = load;
    assign bus_m.pin  = pin;
    assign bus_l.load = load;
    assign bus_l.pin  = pin;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a word accepted at an edge appends W bits to the expected stream.
    bit           exp_msb  [DEPTH];
    bit           exp_lsb  [DEPTH];
    bit           exp_done [DEPTH];
    logic [W-1:0] words    [DEPTH];
    int           wr        = 0;
    int           wwr       = 0;
    int           remaining = 0;
    logic         acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining = 0;
        end else begin
            acc = load && (remaining <= 1);
            if (remaining > 0) remaining = remaining - 1;
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    exp_msb[wr+i]  = pin[W-1-i];
                    exp_lsb[wr+i]  = pin[i];
                    exp_done[wr+i] = (i == W - 1);
                end
                wr          = wr + W;
                words[wwr]  = pin;
                wwr         = wwr + 1;
                remaining   = remaining + W;
            end
        end
    end

    int           tests = 0;
    int           fails = 0;
    int           rd    = 0;
    int           wrd   = 0;
    logic [W-1:0] rx    = '0;
    logic         exp_valid;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: samples 1 ns after each falling clock edge and after any reset assertion.
    initial begin
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (!rst) begin
                check("rst_ready_m", bus_m.ready, 0);
                check("rst_ready_l", bus_l.ready, 0);
                check("rst_sout_m", bus_m.sout, 0);
                check("rst_sout_l", bus_l.sout, 0);
                check("rst_valid_m", bus_m.sout_valid, 0);
                check("rst_valid_l", bus_l.sout_valid, 0);
                check("rst_done_m", bus_m.done, 0);
                check("rst_done_l", bus_l.done, 0);
                rd  = wr;
                wrd = wwr;
            end else begin
                check("ready_m", bus_m.ready, (remaining <= 1) ? 1 : 0);
                check("ready_l", bus_l.ready, (remaining <= 1) ? 1 : 0);
                exp_valid = (rd < wr);
                check("valid_m", bus_m.sout_valid, exp_valid);
                check("valid_l", bus_l.sout_valid, exp_valid);
                if (exp_valid) begin
                    check("sout_m", bus_m.sout, exp_msb[rd]);
                    check("sout_l", bus_l.sout, exp_lsb[rd]);
                    check("done_m", bus_m.done, exp_done[rd]);
                    check("done_l", bus_l.done, exp_done[rd]);
                    rd = rd + 1;
                end else begin
                    check("idle_sout_m", bus_m.sout, 0);
                    check("idle_sout_l", bus_l.sout, 0);
                    check("idle_done_m", bus_m.done, 0);
                    check("idle_done_l", bus_l.done, 0);
                end
                // Loopback receiver: MSB-first shift-in, word presented on the done bit.
                if (bus_m.sout_valid) begin
                    rx = {rx[W-2:0], bus_m.sout};
                    if (bus_m.done) begin
                        if (wrd < wwr) begin
                            check("loopback_word", rx, words[wrd]);
                            wrd = wrd + 1;
                        end else begin
                            check("loopback_extra_word", 1, 0);
                        end
                    end
                end
            end
            if (end_req) begin
                check("stream_drained", rd, wr);
                check("words_drained", wrd, wwr);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    task automatic cyc(input logic l, input logic [W-1:0] p);
        load = l;
        pin  = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        load    = 1'b0;
        pin     = '0;
        end_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, '0);

        cyc(1'b1, 4'b1011);
        repeat (6) cyc(1'b0, '0);

        cyc(1'b1, 4'b1100);
        repeat (4) cyc(1'b1, 4'b0011);
        repeat (6) cyc(1'b0, '0);

        cyc(1'b1, 4'b1111);
        cyc(1'b0, '0);
        cyc(1'b1, 4'b0101);
        repeat (6) cyc(1'b0, '0);

        cyc(1'b1, 4'b1010);
        load = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 4'b0110);
        repeat (6) cyc(1'b0, '0);

        cyc(1'b1, 4'b1001);
        repeat (6) cyc(1'b0, '0);

        repeat (300) cyc(1'($urandom_range(0, 1)), W'($urandom));
        repeat (2) cyc(1'b1, W'($urandom));
        repeat (10) cyc(1'b0, '0);
        end_req = 1'b1;
        repeat (20) @(posedge clk);
        $display("FAIL monitor_timeout: monitor did not end the run");
        $fatal(1);
    end

endmodule
